// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit (with helper addsub)
//  Purpose  : 64-bit restoring divider, signed or unsigned, one quotient bit
//             per cycle, MSB first. Zero divisor and signed overflow are
//             resolved directly from IDLE without iterating.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// addsub: 64-bit adder/subtractor. sel=1 computes a - b as a + ~b + 1, so
// cout=1 means no borrow (a >= b when both are treated as unsigned).
// ----------------------------------------------------------------------------
module addsub (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        sel,
  output logic [63:0] result,
  output logic        cout
);
  logic [63:0] w_b_in;

  assign w_b_in         = sel ? ~b : b;
  assign {cout, result} = {1'b0, a} + {1'b0, w_b_in} + {64'd0, sel};
endmodule

// ----------------------------------------------------------------------------
// div_unit
// ----------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero
);
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_CALC   = 2'd1;
  localparam logic [1:0]  S_FIX    = 2'd2;
  localparam logic [1:0]  S_DONE   = 2'd3;
  localparam logic [6:0]  C_LAST   = 7'd63;
  localparam logic [63:0] C_MIN    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] C_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [6:0]  r_cnt;
  logic [63:0] r_rem;      // partial remainder
  logic [63:0] r_quo;      // dividend bits shift out, quotient bits shift in
  logic [63:0] r_div;      // divisor magnitude
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_zero;
  logic        w_ovf;
  logic [63:0] w_abs_dd;
  logic [63:0] w_abs_dv;
  logic [63:0] w_shift;
  logic        w_shout;
  logic [63:0] w_diff;
  logic        w_cout;
  logic        w_ok;

  assign w_zero   = (divisor == 64'd0);
  assign w_ovf    = is_signed && (dividend == C_MIN) && (divisor == C_ONES);
  assign w_abs_dd = (is_signed && dividend[63]) ? (~dividend + 64'd1) : dividend;
  assign w_abs_dv = (is_signed && divisor[63])  ? (~divisor  + 64'd1) : divisor;

  // Shift the next dividend bit into the partial remainder; the bit pushed
  // out of the top still counts, since the true value is then >= 2^64.
  assign w_shift  = {r_rem[62:0], r_quo[63]};
  assign w_shout  = r_rem[63];

  addsub u_addsub (
    .a      (w_shift),
    .b      (r_div),
    .sel    (1'b1),
    .result (w_diff),
    .cout   (w_cout)
  );

  assign w_ok = w_cout | w_shout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (w_zero || w_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == C_LAST) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 7'd0;
      r_rem       <= 64'd0;
      r_quo       <= 64'd0;
      r_div       <= 64'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient    <= 64'd0;
      remainder   <= 64'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero) begin
              quotient    <= C_ONES;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (w_ovf) begin
              quotient    <= dividend;
              remainder   <= 64'd0;
              div_by_zero <= 1'b0;
            end else begin
              r_cnt   <= 7'd0;
              r_rem   <= 64'd0;
              r_quo   <= w_abs_dd;
              r_div   <= w_abs_dv;
              r_neg_q <= is_signed & (dividend[63] ^ divisor[63]);
              r_neg_r <= is_signed & dividend[63];
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ok ? w_diff : w_shift;
          r_quo <= {r_quo[62:0], w_ok};
          r_cnt <= r_cnt + 7'd1;
        end
        S_FIX: begin
          quotient    <= r_neg_q ? (~r_quo + 64'd1) : r_quo;
          remainder   <= r_neg_r ? (~r_rem + 64'd1) : r_rem;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Scoreboard bench for div_unit: directed corner cases plus
//             randomized operations against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  localparam logic [63:0] C_MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] C_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
    int          lat;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_acc = 0;
  int   busy_n = 0;
  int   done_cnt = 0;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic, with the two special cases first.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t e;
    logic signed [63:0] sa, sd;
    sa = a;
    sd = b;
    if (b == 64'd0) begin
      e.q = C_ONES; e.r = a; e.z = 1'b1; e.lat = 1;
    end else if (s && a == C_MIN && b == C_ONES) begin
      e.q = a; e.r = 64'd0; e.z = 1'b0; e.lat = 1;
    end else if (s) begin
      e.q = sa / sd; e.r = sa % sd; e.z = 1'b0; e.lat = 66;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = 66;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks acceptance time and busy span, checks every done pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && start && !busy) begin
        t_acc  = cyc + 1;
        busy_n = 0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_cnt++;
        if (scb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = scb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.z});
          chk("latency", 64'(cyc - t_acc + 1), 64'(e.lat));
          chk("busy_cycles", 64'(busy_n), 64'(e.lat));
        end
      end
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target);
    end
  endtask

  task automatic drive_start(input logic [63:0] a, input logic [63:0] b, input logic s);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    is_signed = 1'($urandom);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    int target;
    target = done_cnt + 1;
    scb.push_back(model(a, b, s));
    drive_start(a, b, s);
    wait_done(target);
  endtask

  initial begin
    int base;
    int n;
    logic [63:0] a, b;
    logic s;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);

    // Directed cases
    run_op(64'd100, 64'd7, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_quotient", quotient, 64'd14);
    chk("hold_remainder", remainder, 64'd2);
    run_op(C_ONES, 64'h8000_0000_0000_0001, 1'b0);
    run_op(-64'sd7, 64'd2, 1'b1);
    run_op(64'd7, -64'sd2, 1'b1);
    run_op(64'h1234, 64'd0, 1'b0);
    run_op(C_MIN, C_ONES, 1'b1);
    run_op(64'h55, 64'd0, 1'b1);

    // Start while busy is ignored: one done with the first operation's result
    base = done_cnt;
    scb.push_back(model(64'd50, 64'd5, 1'b0));
    drive_start(64'd50, 64'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; dividend = 64'd9; divisor = 64'd3; is_signed = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    wait_done(base + 1);
    repeat (80) @(posedge clk);
    chk("single_done", 64'(done_cnt - base), 64'd1);

    // Start during the DONE cycle is ignored
    scb.push_back(model(64'd20, 64'd6, 1'b0));
    drive_start(64'd20, 64'd6, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    start = 1'b1; dividend = 64'd5; divisor = 64'd1; is_signed = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("done_cycle_start_ignored", {63'd0, busy}, 64'd0);

    // Reset mid-operation abandons it
    drive_start(64'd123456, 64'd7, 1'b0);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_quotient", quotient, 64'd0);
    chk("midrst_remainder", remainder, 64'd0);
    chk("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
    base = done_cnt;
    repeat (80) @(posedge clk);
    chk("midrst_no_done", 64'(done_cnt - base), 64'd0);
    run_op(64'd9, 64'd3, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = 64'($urandom_range(1, 20));
        1: b = 64'd0;
        2: begin a = C_MIN; b = C_ONES; end
        3: b = b >> $urandom_range(0, 63);
        default: ;
      endcase
      run_op(a, b, s);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(scb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
